// File: rtl/uart_mm_pkg.sv
// Shared definitions for the UART-fed sequential matrix multiplier:
// FSM encoding, error causes and width helpers.
package uart_mm_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD_A  = 3'd1,
    S_LOAD_B  = 3'd2,
    S_COMPUTE = 3'd3,
    S_SEND    = 3'd4
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT = 2'd1;
  localparam logic [1:0] ERR_RX      = 2'd2;

  // ceil(log2(value)); 0 for value <= 1
  function automatic int clog2(input int value);
    int r;
    int x;
    r = 0;
    x = value - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

  // Accumulator width: full product plus headroom for N partial sums
  function automatic int res_width(input int n, input int elem_w);
    return 2 * elem_w + clog2(n);
  endfunction

  function automatic int res_bytes(input int n, input int elem_w);
    return (res_width(n, elem_w) + 7) / 8;
  endfunction

  // Index width for a counter over 'count' values, never narrower than 1 bit
  function automatic int idx_width(input int count);
    return (count > 1) ? clog2(count) : 1;
  endfunction

endpackage

// File: rtl/mm_mac_engine.sv
// Single-MAC sequential engine: for each C[i][j] in row-major order it
// spends N cycles accumulating A[i][k]*B[k][j] and one cycle writing the result.
module mm_mac_engine
  import uart_mm_pkg::*;
#(
  parameter int N      = 3,
  parameter int ELEM_W = 8,
  localparam int RES_W = res_width(N, ELEM_W),
  localparam int AW    = idx_width(N * N)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ELEM_W-1:0] a_data,
  input  logic [ELEM_W-1:0] b_data,
  output logic [AW-1:0]     a_addr,
  output logic [AW-1:0]     b_addr,
  output logic              c_we,
  output logic [AW-1:0]     c_addr,
  output logic [RES_W-1:0]  c_data,
  output logic              done
);

  localparam int CW = idx_width(N + 1);

  logic                  run;
  logic [CW-1:0]         i_q;
  logic [CW-1:0]         j_q;
  logic [CW-1:0]         k_q;
  logic [RES_W-1:0]      acc;
  logic [2*ELEM_W-1:0]   prod;
  logic                  write_phase;
  logic                  last_elem;

  always_comb begin
    prod        = {{ELEM_W{1'b0}}, a_data} * {{ELEM_W{1'b0}}, b_data};
    write_phase = run && (k_q == CW'(N));
    last_elem   = (i_q == CW'(N - 1)) && (j_q == CW'(N - 1));
    // k reaches N only in the write cycle; park the read addresses in range then
    a_addr      = '0;
    b_addr      = '0;
    if (!write_phase) begin
      a_addr = AW'(int'(i_q) * N + int'(k_q));
      b_addr = AW'(int'(k_q) * N + int'(j_q));
    end
    c_addr      = AW'(int'(i_q) * N + int'(j_q));
    c_we        = write_phase;
    c_data      = acc;
    done        = write_phase && last_elem;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      run <= 1'b0;
      i_q <= '0;
      j_q <= '0;
      k_q <= '0;
      acc <= '0;
    end else if (start) begin
      run <= 1'b1;
      i_q <= '0;
      j_q <= '0;
      k_q <= '0;
      acc <= '0;
    end else if (run) begin
      if (!write_phase) begin
        acc <= acc + RES_W'(prod);
        k_q <= k_q + 1'b1;
      end else begin
        acc <= '0;
        k_q <= '0;
        if (j_q == CW'(N - 1)) begin
          j_q <= '0;
          if (i_q == CW'(N - 1)) begin
            i_q <= '0;
            run <= 1'b0;
          end else begin
            i_q <= i_q + 1'b1;
          end
        end else begin
          j_q <= j_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/uart_matmul_seq.sv
// UART matrix-multiply controller: loads A and B as a byte stream, computes
// C = A x B on a single-MAC engine and streams C out over a byte handshake.
module uart_matmul_seq
  import uart_mm_pkg::*;
#(
  parameter int N              = 3,
  parameter int ELEM_W         = 8,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       rx_err,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [2:0] state,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] err_code
);

  localparam int EB     = ELEM_W / 8;
  localparam int NN     = N * N;
  localparam int RES_W  = res_width(N, ELEM_W);
  localparam int RB     = res_bytes(N, ELEM_W);
  localparam int AW     = idx_width(NN);
  localparam int EBW    = idx_width(EB);
  localparam int RBW    = idx_width(RB);
  localparam int TW     = idx_width(TIMEOUT_CYCLES + 1);
  localparam int TO_END = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

  logic [ELEM_W-1:0] a_mem [NN];
  logic [ELEM_W-1:0] b_mem [NN];
  logic [RB-1:0][7:0] c_mem [NN];

  state_t          state_q;
  logic [AW-1:0]   elem_q;
  logic [EBW-1:0]  byte_q;
  logic [TW-1:0]   idle_q;
  logic [AW-1:0]   tx_elem_q;
  logic [RBW-1:0]  tx_byte_q;
  logic [7:0]      tx_data_q;
  logic            tx_valid_q;
  logic            done_q;
  logic            err_q;
  logic [1:0]      err_code_q;

  logic [AW-1:0]   elem_nxt;
  logic [EBW-1:0]  byte_nxt;
  logic            loading;
  logic            load_last;
  logic            wr_a;
  logic            wr_b;
  logic            eng_start;
  logic            timeout_hit;
  logic            tx_fire;
  logic            tx_last;

  logic [AW-1:0]    a_addr;
  logic [AW-1:0]    b_addr;
  logic             c_we;
  logic [AW-1:0]    c_addr;
  logic [RES_W-1:0] c_data;
  logic             eng_done;

  always_comb begin
    loading   = (state_q == S_LOAD_A) || (state_q == S_LOAD_B);
    load_last = (elem_q == AW'(NN - 1)) && (byte_q == EBW'(EB - 1));
    if (byte_q == EBW'(EB - 1)) begin
      byte_nxt = '0;
      elem_nxt = elem_q + 1'b1;
    end else begin
      byte_nxt = byte_q + 1'b1;
      elem_nxt = elem_q;
    end
    // In IDLE the load counters sit at zero, so the first byte lands in A[0][0]
    wr_a        = !reset && rx_valid &&
                  ((state_q == S_IDLE) || ((state_q == S_LOAD_A) && !rx_err));
    wr_b        = !reset && rx_valid && (state_q == S_LOAD_B) && !rx_err;
    eng_start   = wr_b && load_last;
    timeout_hit = (TIMEOUT_CYCLES != 0) && loading && !rx_valid &&
                  (idle_q == TW'(TO_END));
    tx_fire     = tx_valid_q && tx_ready;
    tx_last     = (tx_byte_q == RBW'(RB - 1)) && (tx_elem_q == AW'(NN - 1));
  end

  mm_mac_engine #(
    .N      (N),
    .ELEM_W (ELEM_W)
  ) u_engine (
    .clk    (clk),
    .reset  (reset),
    .start  (eng_start),
    .a_data (a_mem[a_addr]),
    .b_data (b_mem[b_addr]),
    .a_addr (a_addr),
    .b_addr (b_addr),
    .c_we   (c_we),
    .c_addr (c_addr),
    .c_data (c_data),
    .done   (eng_done)
  );

  // Matrix storage survives reset; only the control path is cleared.
  always_ff @(posedge clk) begin
    for (int b = 0; b < EB; b++) begin
      if (wr_a && (int'(byte_q) == b)) a_mem[elem_q][8*b +: 8] <= rx_data;
      if (wr_b && (int'(byte_q) == b)) b_mem[elem_q][8*b +: 8] <= rx_data;
    end
    if (c_we && !reset) c_mem[c_addr] <= (RB * 8)'(c_data);
  end

  // Output handshake: a byte transfers on a cycle with tx_valid & tx_ready;
  // while tx_valid is high and tx_ready low, tx_data holds its value.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      elem_q     <= '0;
      byte_q     <= '0;
      idle_q     <= '0;
      tx_elem_q  <= '0;
      tx_byte_q  <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (rx_valid) begin
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
            elem_q     <= elem_nxt;
            byte_q     <= byte_nxt;
            idle_q     <= '0;
            state_q    <= S_LOAD_A;
          end
        end
        S_LOAD_A, S_LOAD_B: begin
          if (rx_err || timeout_hit) begin
            err_q      <= 1'b1;
            err_code_q <= rx_err ? ERR_RX : ERR_TIMEOUT;
            elem_q     <= '0;
            byte_q     <= '0;
            idle_q     <= '0;
            state_q    <= S_IDLE;
          end else if (rx_valid) begin
            idle_q <= '0;
            if (load_last) begin
              elem_q  <= '0;
              byte_q  <= '0;
              state_q <= (state_q == S_LOAD_A) ? S_LOAD_B : S_COMPUTE;
            end else begin
              elem_q <= elem_nxt;
              byte_q <= byte_nxt;
            end
          end else begin
            idle_q <= idle_q + 1'b1;
          end
        end
        S_COMPUTE: begin
          // C[0][0] was written long before the final element, so it is ready now
          if (eng_done) begin
            tx_elem_q  <= '0;
            tx_byte_q  <= '0;
            tx_data_q  <= c_mem[0][0];
            tx_valid_q <= 1'b1;
            state_q    <= S_SEND;
          end
        end
        S_SEND: begin
          if (tx_fire) begin
            if (tx_last) begin
              tx_valid_q <= 1'b0;
              tx_data_q  <= '0;
              tx_elem_q  <= '0;
              tx_byte_q  <= '0;
              done_q     <= 1'b1;
              state_q    <= S_IDLE;
            end else if (tx_byte_q == RBW'(RB - 1)) begin
              tx_elem_q <= tx_elem_q + 1'b1;
              tx_byte_q <= '0;
              tx_data_q <= c_mem[tx_elem_q + 1'b1][0];
            end else begin
              tx_byte_q <= tx_byte_q + 1'b1;
              tx_data_q <= c_mem[tx_elem_q][tx_byte_q + 1'b1];
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign state    = state_q;
  assign busy     = (state_q != S_IDLE);
  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign done     = done_q;
  assign err      = err_q;
  assign err_code = err_code_q;

endmodule

// File: doc/uart_matmul_seq.md
Name: uart_matmul_seq

Overview:
- Parametrised successor to the fixed 3x3, 8-bit UART matrix-multiply controller.
- Receives two N x N matrices as a UART byte stream, computes C = A x B with an internal single-MAC sequential engine, and streams C back through a valid/ready byte handshake.
- Sits between the UART receiver/transmitter (all signals already in the clk domain) and the board-level status logic.
- Adds behaviour the 3x3 controller lacks: multi-byte elements, an inter-byte timeout, receive-error abort, and TX backpressure.

Parameters:
- N, 3, matrix dimension (2..8).
- ELEM_W, 8, element width in bits; must be a multiple of 8 (8 or 16).
- TIMEOUT_CYCLES, 1000000, maximum clk cycles between RX bytes while loading; 0 disables the timeout.
- Derived localparams:
  - EB = ELEM_W/8
  - RES_W = 2*ELEM_W + clog2(N)
  - RB = ceil(RES_W/8)

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- rx_data  in  8  received byte.
- rx_valid  in  1  one-cycle pulse; rx_data is valid this cycle.
- rx_err  in  1  one-cycle pulse on a UART framing error.
- tx_data  out  8  byte to transmit.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  transmitter accepts; a byte transfers on tx_valid & tx_ready.
- state  out  3  current FSM state code.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse after the last result byte transfers.
- err  out  1  sticky error flag.
- err_code  out  2  cause of err: 1 = timeout, 2 = rx_err.

Behaviour:
- Reset:
  - Takes effect on any clk edge with reset=1, including mid-operation; aborts all activity.
  - Outputs: state=IDLE, tx_valid=0, tx_data=0, done=0, err=0, err_code=0, busy=0.
  - All counters cleared. Matrix storage is not cleared.
- States: IDLE=0, LOAD_A=1, LOAD_B=2, COMPUTE=3, SEND=4.
- Byte order:
  - Elements are row-major; index e = i*N + j.
  - Each element is EB bytes, little-endian.
  - A is sent first, then B. Total input is 2*N*N*EB bytes.
- IDLE:
  - First rx_valid byte is stored as byte 0 of A[0][0].
  - On that byte: clear err and err_code, go to LOAD_A.
- LOAD_A / LOAD_B:
  - Each rx_valid byte is written at the current byte/element counter position.
  - After byte N*N*EB of A, go to LOAD_B.
  - After byte N*N*EB of B, go to COMPUTE on the next cycle.
- Timeout:
  - The idle counter increments every cycle without rx_valid in LOAD_A or LOAD_B, and resets on each rx_valid.
  - Reaching TIMEOUT_CYCLES sets err=1, err_code=1 and returns to IDLE. Partial data is discarded.
- rx_err:
  - In LOAD_A or LOAD_B: same abort as the timeout, with err_code=2.
  - In any other state: ignored.
- rx_valid outside IDLE, LOAD_A and LOAD_B is ignored; no buffering.
- COMPUTE, per (i,j) in row-major order:
  - Clear acc.
  - N cycles of acc += A[i][k]*B[k][j], for k = 0..N-1.
  - 1 cycle to write C[i][j].
  - Total latency from COMPUTE entry to SEND entry is exactly N*N*(N+1) cycles.
  - Operands are unsigned. acc is RES_W bits and cannot overflow.
- SEND:
  - Emits C row-major, RB bytes per element, little-endian; upper unused bits are zero.
  - tx_valid asserts on SEND entry.
  - tx_data must hold stable while tx_valid=1 and tx_ready=0.
  - On each transfer, advance to the next byte; tx_valid stays high if bytes remain.
  - After the final transfer: tx_valid=0, done pulses for 1 cycle, go to IDLE.
- Back-to-back operation: a new load may begin the cycle after done.

Decomposition:
- Shared package uart_mm_pkg holds:
  - state encoding localparams
  - err_code values
  - a clog2 function
  - RES_W/RB derivation helpers
- Sub-module mm_mac_engine:
  - Ports: start, done, A/B read address, C write enable/address/data.
  - Owns the i/j/k counters and the accumulator.
  - Matrix storage stays in the top level (register arrays).

Test Plan:
- Basic 2x2, N=2, ELEM_W=8 (RB=3):
  - Stimulus: A bytes 01 02 03 04, B bytes 05 06 07 08, tx_ready=1.
  - Response: TX bytes 13 00 00, 16 00 00, 2B 00 00, 32 00 00.
  - done 1 cycle after the last byte; COMPUTE lasts exactly 12 cycles.
- Worst case, N=3, ELEM_W=8:
  - Stimulus: all elements FF.
  - Response: every C element = 195075 → bytes 03 FA 02, nine times; no overflow.
- 16-bit elements, N=2, ELEM_W=16:
  - Stimulus: A = identity, bytes 01 00 00 00 00 00 01 00; B elements 1234h, 0001h, FFFFh, 0010h.
  - Response: C equals B; RB=5, first element bytes 34 12 00 00 00.
- Timeout, TIMEOUT_CYCLES=100:
  - Stimulus: 5 A bytes, then silence.
  - Response: on cycle 100 after the last byte, err=1, err_code=1, state=IDLE.
  - A following full stream completes correctly and clears err.
- rx_err and reset:
  - rx_err pulse mid-LOAD_B → err_code=2, state=IDLE.
  - Separately, reset asserted mid-COMPUTE → next cycle state=IDLE, tx_valid=0, no done pulse.
- Backpressure:
  - Stimulus: tx_ready toggles 0/1 every 3 cycles during SEND.
  - Response: tx_data stable while stalled; byte count exact (N*N*RB); no byte dropped or duplicated.
